// File: rtl/rr_arbiter8.sv
// Round-robin arbiter: 8 requesters share one decoded select bus; grant registered 1 cycle after request.
// Owner keeps the grant while requesting, bounded to HOLD_MAX cycles when others wait; one idle cycle per handover.
module rr_arbiter8 #(
    parameter int HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_vld
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

    state_t     state;
    logic [2:0] ptr;
    logic [3:0] hold_cnt;
    logic [2:0] cand;
    logic [2:0] win_idx;
    logic       win_found;
    logic       release_now;

    // Scan from lowest to highest priority so the highest-priority hit is the last assignment.
    always_comb begin
        win_idx   = ptr;
        win_found = 1'b0;
        cand      = ptr;
        for (int k = 8; k >= 1; k--) begin
            cand = ptr + 3'(k);
            if (req[cand]) begin
                win_idx   = cand;
                win_found = 1'b1;
            end
        end
    end

    // Saturated hold_cnt (sole requester) must still yield once a competitor shows up, hence >=.
    assign release_now = !en || !req[gnt_idx] ||
                         ((hold_cnt >= HOLD_LIM) && ((req & ~gnt) != 8'h00));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= 3'd7;
            hold_cnt <= 4'd0;
            gnt      <= 8'h00;
            gnt_idx  <= 3'd0;
            gnt_vld  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en && win_found) begin
                        gnt      <= 8'b1 << win_idx;
                        gnt_idx  <= win_idx;
                        gnt_vld  <= 1'b1;
                        hold_cnt <= 4'd1;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        gnt      <= 8'h00;
                        gnt_vld  <= 1'b0;
                        ptr      <= gnt_idx;
                        hold_cnt <= 4'd0;
                        state    <= IDLE;
                    end else if (hold_cnt != 4'hF) begin
                        hold_cnt <= hold_cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed scenarios plus random traffic against a behavioural model.
module tb_rr_arbiter8;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: current owner (-1 = none), last owner for rotation, cycles held so far.
    int m_owner;
    int m_last;
    int m_held;
    int m_idx;

    rr_arbiter8 #(.HOLD_MAX(HOLD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .req     (req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = 7;
        m_held  = 0;
        m_idx   = 0;
    endtask

    task automatic model_edge();
        int others;
        if (!rst_n) return;
        if (m_owner < 0) begin
            if (en && req != 8'h00) begin
                for (int k = 1; k <= 8; k++) begin
                    if (req[(m_last + k) % 8]) begin
                        m_owner = (m_last + k) % 8;
                        break;
                    end
                end
                m_idx  = m_owner;
                m_held = 1;
            end
        end else begin
            others = int'(req) & ~(1 << m_owner) & 8'hFF;
            if (!en || !req[m_owner] || (m_held >= HOLD && others != 0)) begin
                m_last  = m_owner;
                m_owner = -1;
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic compare();
        logic [7:0] eg;
        eg = (m_owner < 0) ? 8'h00 : 8'(1 << m_owner);
        chk("gnt", gnt, eg);
        chk("gnt_vld", {7'd0, gnt_vld}, {7'd0, m_owner >= 0});
        chk("gnt_idx", {5'd0, gnt_idx}, 8'(m_idx));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    // Assert reset asynchronously a couple of ns after a falling edge, check outputs without a clock, release next fall.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_gnt", gnt, 8'h00);
        chk("rst_vld", {7'd0, gnt_vld}, 8'h00);
        chk("rst_idx", {5'd0, gnt_idx}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [7:0] fair_exp;

    initial begin
        model_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        req   = 8'hFF;

        // 1. Reset state and first grant
        #12;
        chk("reset_gnt", gnt, 8'h00);
        chk("reset_vld", {7'd0, gnt_vld}, 8'h00);
        chk("reset_idx", {5'd0, gnt_idx}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("first_gnt", gnt, 8'h01);

        // 2. Release and handover with bubble
        req = 8'b0000_0101;
        tick();
        chk("hold0", gnt, 8'h01);
        req = 8'b0000_0100;
        tick();
        chk("bubble", gnt, 8'h00);
        tick();
        chk("handover", gnt, 8'h04);
        chk("handover_idx", {5'd0, gnt_idx}, 8'd2);

        // 3. Fairness with all requesting: 4 grant cycles then 1 bubble per owner
        async_reset();
        req = 8'hFF;
        for (int c = 0; c < 45; c++) begin
            tick();
            fair_exp = ((c % 5) < 4) ? 8'(1 << ((c / 5) % 8)) : 8'h00;
            chk("fair", gnt, fair_exp);
        end

        // 4. Sole requester holds indefinitely, then yields to a newcomer
        req = 8'h00;
        tick();
        tick();
        req = 8'h08;
        for (int c = 0; c < 20; c++) tick();
        chk("sole_gnt", gnt, 8'h08);
        chk("sole_idx", {5'd0, gnt_idx}, 8'd3);
        req = 8'h28;
        tick();
        chk("sole_drop", gnt, 8'h00);
        tick();
        chk("sole_next", gnt, 8'h20);

        // 5. Enable gating
        async_reset();
        req = 8'h04;
        tick();
        chk("en_pre", gnt, 8'h04);
        en  = 1'b0;
        req = 8'hFF;
        tick();
        chk("en_off", gnt, 8'h00);
        for (int c = 0; c < 4; c++) tick();
        chk("en_off_hold", gnt, 8'h00);
        en = 1'b1;
        tick();
        chk("en_on", gnt, 8'h08);

        // 6. Async reset while requester 6 owns the bus
        req = 8'h40;
        tick();
        tick();
        chk("pre_rst", gnt, 8'h40);
        async_reset();
        req = 8'hC1;
        tick();
        chk("post_rst", gnt, 8'h01);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) req = 8'($urandom);
            if ($urandom_range(0, 7) == 0) req = 8'h00;
            en = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 99) == 0) async_reset();
            else tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
